// File: rtl/en_pulse_gen_pkg.sv
// Shared types and width helpers for the button enable-pulse generator.
package en_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HELD,
    DISARM
  } state_t;

  // Width of a saturating debounce counter that must be able to hold the value 'cycles'.
  function automatic int db_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Width of a repeat counter that runs from 0 up to cycles-1.
  function automatic int rep_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/en_pulse_gen_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Async active-low clear plus sync active-low reset, both forcing every stage to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic CLRN,
  input  logic nRST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; no logic between stages.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      chain <= '0;
    end else if (!nRST) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/en_pulse_gen.sv
// Debounced level and single-cycle enable pulse from a raw pushbutton.
// Optional auto-repeat while the button is held: define AUTOREPEAT_EN.
module en_pulse_gen
  import en_pulse_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic CLK,
  input  logic CLRN,
  input  logic nRST,
  input  logic BTN,
  output logic EN,
  output logic LEVEL
);

  localparam int DBW = db_cnt_width(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_CYCLES);

  // Reject parameter values the debounce/repeat scheme cannot honour.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("en_pulse_gen: SYNC_STAGES must be at least 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("en_pulse_gen: DB_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rep
    $error("en_pulse_gen: REPEAT_CYCLES must be at least 2");
  end

  logic           btn_s;
  state_t         state, state_nx;
  logic [DBW-1:0] cnt, cnt_nx;
  logic           en_q, en_nx;
  logic           level_q, level_nx;
  logic           db_done;

`ifdef AUTOREPEAT_EN
  localparam int RW = rep_cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt, rcnt_nx;
`endif

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .CLRN(CLRN),
    .nRST(nRST),
    .d   (BTN),
    .q   (btn_s)
  );

  // '>=' lets DB_CYCLES=1 leave ARM/DISARM on the first cycle even though entry loads 1.
  assign db_done = (cnt >= DB_LAST);

  // Next-state logic: debounce qualification, pulse generation and level tracking.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    en_nx    = 1'b0;
    level_nx = level_q;
`ifdef AUTOREPEAT_EN
    rcnt_nx  = '0;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx = ARM;
          cnt_nx   = DBW'(1);
        end
      end
      ARM: begin
        if (!btn_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (db_done) begin
          state_nx = HELD;
          cnt_nx   = '0;
          en_nx    = 1'b1;
          level_nx = 1'b1;
        end else if (cnt != DB_MAX) begin
          cnt_nx = cnt + DBW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nx = DISARM;
          cnt_nx   = DBW'(1);
        end
`ifdef AUTOREPEAT_EN
        else if (rcnt == REP_LAST) begin
          en_nx = 1'b1;
        end else begin
          rcnt_nx = rcnt + RW'(1);
        end
`endif
      end
      DISARM: begin
        if (btn_s) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (db_done) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          level_nx = 1'b0;
        end else if (cnt != DB_MAX) begin
          cnt_nx = cnt + DBW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; async clear wins over the sync reset.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state   <= IDLE;
      cnt     <= '0;
      en_q    <= 1'b0;
      level_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      rcnt    <= '0;
`endif
    end else if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      en_q    <= 1'b0;
      level_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      rcnt    <= '0;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      en_q    <= en_nx;
      level_q <= level_nx;
`ifdef AUTOREPEAT_EN
      rcnt    <= rcnt_nx;
`endif
    end
  end

  assign EN    = en_q;
  assign LEVEL = level_q;

endmodule

// File: tb/tb_en_pulse_gen.sv
// Self-checking bench for en_pulse_gen: directed scenarios with literal
// expectations plus randomized button/reset activity against a behavioural model.
module tb_en_pulse_gen;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int REP  = 8;
`ifdef AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic CLK;
  logic CLRN;
  logic nRST;
  logic BTN;
  logic EN;
  logic LEVEL;

  int checks = 0;
  int passes = 0;
  bit cmpOn  = 1'b0;

  // Behavioural model state: level, pulse, run of disagreeing samples, hold time.
  logic mPipe[$];
  logic mLevel;
  logic mEn;
  logic mPrevS;
  int   mRun;
  int   mHold;

  en_pulse_gen #(
    .SYNC_STAGES  (SYNC),
    .DB_CYCLES    (DB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .CLK  (CLK),
    .CLRN (CLRN),
    .nRST (nRST),
    .BTN  (BTN),
    .EN   (EN),
    .LEVEL(LEVEL)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %b required %b at %0t", name, got, exp, $time);
  endtask

  task automatic modelReset();
    mPipe.delete();
    for (int i = 0; i < SYNC; i++) mPipe.push_back(1'b0);
    mLevel = 1'b0;
    mEn    = 1'b0;
    mPrevS = 1'b0;
    mRun   = 0;
    mHold  = 0;
  endtask

  // The level flips once DB consecutive synchronized samples disagree with it;
  // while held, every REP further high samples give another pulse.
  task automatic modelStep(input logic b);
    logic s;
    s = mPipe.pop_front();
    mPipe.push_back(b);
    mEn = 1'b0;
    if (s != mLevel) mRun++;
    else mRun = 0;
    if (mRun >= DB) begin
      mLevel = s;
      mRun   = 0;
      mHold  = 0;
      if (s) mEn = 1'b1;
    end else if (mLevel && s && mPrevS) begin
      mHold++;
      if (mHold == REP) begin
        mHold = 0;
        mEn   = AUTOREP;
      end
    end else begin
      mHold = 0;
    end
    mPrevS = s;
  endtask

  // Model follows the same clock and both resets.
  always @(posedge CLK or negedge CLRN) begin
    if (!CLRN || !nRST) modelReset();
    else modelStep(BTN);
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (cmpOn) begin
      checkOutput("cmp_en", EN, mEn);
      checkOutput("cmp_level", LEVEL, mLevel);
    end
  end

  // Drive BTN to b and let n rising edges pass; returns 2 units after the last edge.
  task automatic applyStimulus(input logic b, input int n);
    BTN = b;
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    int pulses;
    int n;
    bit got;
    logic b;

    CLRN = 1'b1;
    nRST = 1'b1;
    BTN  = 1'b0;
    #1 CLRN = 1'b0;
    @(posedge CLK);
    #2;
    checkOutput("reset_en", EN, 1'b0);
    checkOutput("reset_level", LEVEL, 1'b0);
    CLRN = 1'b1;
    cmpOn = 1'b1;
    applyStimulus(1'b0, 3);

    // Clean press held long enough to see any auto-repeat pulses.
    BTN = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge CLK);
      #2;
      checkOutput($sformatf("press_en_%0d", k), EN,
                  (k == SYNC + DB) || (AUTOREP && k > SYNC + DB && (k - SYNC - DB) % REP == 0));
      checkOutput($sformatf("press_level_%0d", k), LEVEL, k >= SYNC + DB);
      if (EN === 1'b1) pulses++;
    end
    checks++;
    if (pulses == (AUTOREP ? 4 : 1)) passes++;
    else $display("[TB] FAIL press_pulse_count: got %0d required %0d", pulses, AUTOREP ? 4 : 1);

    // Clean release: level drops after SYNC+DB edges, no pulse.
    BTN = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #2;
      checkOutput($sformatf("release_en_%0d", k), EN, 1'b0);
      checkOutput($sformatf("release_level_%0d", k), LEVEL, k < SYNC + DB);
    end

    // Bounce: a short burst is rejected, the steady rise pulses once.
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 1);
    BTN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #2;
      checkOutput($sformatf("bounce_en_%0d", k), EN, k == SYNC + DB);
    end

    // Release glitch while held: level stays high, no extra pulse.
    applyStimulus(1'b0, 2);
    BTN = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK);
      #2;
      checkOutput($sformatf("glitch_en_%0d", k), EN, 1'b0);
      checkOutput($sformatf("glitch_level_%0d", k), LEVEL, 1'b1);
    end
    applyStimulus(1'b0, 8);

    // Sync reset while debouncing restarts the full qualification.
    applyStimulus(1'b1, 3);
    nRST = 1'b0;
    @(posedge CLK);
    #2;
    checkOutput("nrst_en", EN, 1'b0);
    nRST = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #2;
      checkOutput($sformatf("nrst_after_en_%0d", k), EN, k == SYNC + DB);
    end
    applyStimulus(1'b0, 8);

    // Async clear while the pulse is high drops outputs without a clock edge.
    BTN = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge CLK);
      #2;
      if (mEn) got = 1'b1;
    end
    if (!got) begin
      checks++;
      $display("[TB] FAIL clrn_wait: got no pulse required pulse within 20 cycles");
    end else begin
      checkOutput("clrn_pre_en", EN, 1'b1);
      CLRN = 1'b0;
      #1;
      checkOutput("clrn_en", EN, 1'b0);
      checkOutput("clrn_level", LEVEL, 1'b0);
      #1 CLRN = 1'b1;
    end
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 8);

    // Randomized runs of button levels with occasional resets of either kind.
    for (int i = 0; i < 120; i++) begin
      b = 1'($urandom_range(0, 1));
      n = (b && $urandom_range(0, 3) == 0) ? int'($urandom_range(10, 24)) : int'($urandom_range(1, 7));
      BTN = b;
      repeat (n) begin
        n = int'($urandom_range(0, 99));
        nRST = (n < 2) ? 1'b0 : 1'b1;
        if (n == 2) begin
          CLRN = 1'b0;
          #1 CLRN = 1'b1;
        end
        @(posedge CLK);
        #2;
      end
    end
    nRST = 1'b1;
    applyStimulus(1'b0, 10);

    cmpOn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
